wb_data_responder: RTL and testbench

- Pipelined Wishbone B4 responder: the slave end of the core's data-bus master port.
- Holds a word-addressed data RAM with byte-lane writes and a fixed, parameterised response latency.
- Throttles the master through wb_stall via an outstanding-request limit and a periodic bank-conflict stall.
- Flags out-of-range addresses with wb_err.
- Instantiated beside the core in the SoC top; drives the memory stage's ack/err/stall/miso inputs.

---
 rtl/wb_pkg.sv | 28 ++
 rtl/wb_resp_pipe.sv | 46 ++++
 rtl/wb_data_responder.sv | 137 +++++++++++++
 tb/tb_wb_data_responder.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone data responder: response record,
// address width and the decode-window check.
package wb_pkg;

    localparam int WB_ADDR_W = 30;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] data;
    } wb_rsp_t;

    // One extra bit keeps BASE+DEPTH from wrapping at the top of the address space.
    function automatic logic addr_in_range(
        input logic [WB_ADDR_W-1:0] addr,
        input logic [WB_ADDR_W-1:0] base,
        input int                   depth
    );
        logic [WB_ADDR_W:0] a;
        logic [WB_ADDR_W:0] lo;
        logic [WB_ADDR_W:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + (WB_ADDR_W+1)'(depth);
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/wb_resp_pipe.sv
// Fixed-depth shift register of responses; flush empties every stage on the
// next edge, reset empties them immediately.
module wb_resp_pipe
    import wb_pkg::*;
#(
    parameter int STAGES = 1
) (
    input  logic    i_clk,
    input  logic    i_reset,
    input  logic    flush,
    input  wb_rsp_t rsp_in,
    output wb_rsp_t rsp_out,
    output logic    next_valid
);

    genvar gi;
    generate
        if (STAGES == 0) begin : g_bypass
            assign rsp_out    = rsp_in;
            assign next_valid = rsp_in.valid;
        end else begin : g_pipe
            for (gi = 0; gi < STAGES; gi++) begin : g_stage
                wb_rsp_t d;
                wb_rsp_t q;
                if (gi == 0) begin : g_first
                    assign d = rsp_in;
                end else begin : g_rest
                    assign d = g_stage[gi-1].q;
                end
                always_ff @(posedge i_clk or posedge i_reset) begin
                    if (i_reset) begin
                        q <= '0;
                    end else if (flush) begin
                        q <= '0;
                    end else begin
                        q <= d;
                    end
                end
            end
            assign rsp_out    = g_stage[STAGES-1].q;
            // What the last stage will present next cycle.
            assign next_valid = g_stage[STAGES-1].d.valid;
        end
    endgenerate

endmodule

// File: rtl/wb_data_responder.sv
// Pipelined Wishbone slave: word RAM with byte lanes, fixed response latency,
// occupancy and periodic stalls, error response outside the decode window.
module wb_data_responder
    import wb_pkg::*;
#(
    parameter int                   DEPTH_WORDS     = 4096,
    parameter logic [WB_ADDR_W-1:0] BASE_WORD       = '0,
    parameter int                   LATENCY         = 2,
    parameter int                   MAX_OUTSTANDING = 4,
    parameter int                   STALL_EVERY     = 0
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 wb_cyc,
    input  logic                 wb_stb,
    input  logic                 wb_we,
    input  logic [WB_ADDR_W-1:0] wb_addr,
    input  logic [3:0]           wb_sel,
    input  logic [31:0]          wb_mosi,
    output logic [31:0]          wb_miso,
    output logic                 wb_ack,
    output logic                 wb_err,
    output logic                 wb_stall
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int CNT_W = 4;
    localparam int SE_W  = $clog2(STALL_EVERY + 2);

    logic             accept;
    logic             in_range;
    logic [IDX_W-1:0] ram_idx;
    logic             flush;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [31:0]      rd_word_reg;

    logic             head_valid_reg;
    logic             head_err_reg;
    logic             head_rd_reg;
    wb_rsp_t          head_rsp;
    wb_rsp_t          tail_rsp;
    logic             tail_next_valid;

    logic [CNT_W-1:0] out_cnt_reg;
    logic [CNT_W-1:0] out_cnt_next;
    logic [SE_W-1:0]  acc_cnt_reg;
    logic [SE_W-1:0]  acc_cnt_next;
    logic             pattern_hit;
    logic             leaving;
    logic             will_leave;
    logic             stall_reg;
    logic             stall_next;

    assign in_range = addr_in_range(wb_addr, BASE_WORD, DEPTH_WORDS);
    assign ram_idx  = IDX_W'(wb_addr - BASE_WORD);
    assign accept   = wb_cyc & wb_stb & ~stall_reg & ~i_reset;
    assign flush    = ~wb_cyc;

    // Writes commit at the accept edge, so a read accepted one edge later sees them.
    always_ff @(posedge i_clk) begin
        if (accept && in_range) begin
            if (wb_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (wb_sel[i]) begin
                        mem[ram_idx][8*i +: 8] <= wb_mosi[8*i +: 8];
                    end
                end
            end else begin
                rd_word_reg <= mem[ram_idx];
            end
        end
    end

    // Head stage: the RAM output register supplies read data one cycle after acceptance.
    assign head_rsp = {head_valid_reg, head_err_reg, (head_rd_reg ? rd_word_reg : 32'h0)};

    wb_resp_pipe #(
        .STAGES(LATENCY - 1)
    ) u_pipe (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .flush     (flush),
        .rsp_in    (head_rsp),
        .rsp_out   (tail_rsp),
        .next_valid(tail_next_valid)
    );

    assign leaving    = tail_rsp.valid;
    assign will_leave = (LATENCY == 1) ? accept : tail_next_valid;

    always_comb begin
        acc_cnt_next = acc_cnt_reg;
        pattern_hit  = 1'b0;
        if (STALL_EVERY > 0 && accept) begin
            if (acc_cnt_reg + SE_W'(1) == SE_W'(STALL_EVERY)) begin
                acc_cnt_next = '0;
                pattern_hit  = 1'b1;
            end else begin
                acc_cnt_next = acc_cnt_reg + SE_W'(1);
            end
        end
    end

    always_comb begin
        out_cnt_next = '0;
        if (wb_cyc) begin
            out_cnt_next = out_cnt_reg + CNT_W'(accept) - CNT_W'(leaving);
        end
        // A full window only stalls if no slot frees up in the coming cycle.
        stall_next = ((out_cnt_next == CNT_W'(MAX_OUTSTANDING)) && !will_leave) || pattern_hit;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            head_valid_reg <= 1'b0;
            head_err_reg   <= 1'b0;
            head_rd_reg    <= 1'b0;
            out_cnt_reg    <= '0;
            acc_cnt_reg    <= '0;
            stall_reg      <= 1'b0;
        end else begin
            head_valid_reg <= accept;
            head_err_reg   <= accept & ~in_range;
            head_rd_reg    <= accept & in_range & ~wb_we;
            out_cnt_reg    <= out_cnt_next;
            acc_cnt_reg    <= acc_cnt_next;
            stall_reg      <= stall_next;
        end
    end

    assign wb_ack   = wb_cyc & tail_rsp.valid & ~tail_rsp.err;
    assign wb_err   = wb_cyc & tail_rsp.valid & tail_rsp.err;
    assign wb_miso  = wb_ack ? tail_rsp.data : 32'h0;
    assign wb_stall = stall_reg;

endmodule

// File: tb/tb_wb_data_responder.sv
// Directed bench for wb_data_responder with a queue-based transaction model
// checked every cycle, plus hand-computed literal expectations.
module tb_wb_data_responder;

    localparam int          LAT   = 3;
    localparam int          MAXO  = 2;
    localparam int          SE    = 5;
    localparam int          DEPTH = 256;
    localparam logic [29:0] BASE  = 30'h100;

    logic        i_clk   = 1'b0;
    logic        i_reset = 1'b1;
    logic        wb_cyc  = 1'b0;
    logic        wb_stb  = 1'b0;
    logic        wb_we   = 1'b0;
    logic [29:0] wb_addr = '0;
    logic [3:0]  wb_sel  = '0;
    logic [31:0] wb_mosi = '0;
    logic [31:0] wb_miso;
    logic        wb_ack;
    logic        wb_err;
    logic        wb_stall;

    wb_data_responder #(
        .DEPTH_WORDS    (DEPTH),
        .BASE_WORD      (BASE),
        .LATENCY        (LAT),
        .MAX_OUTSTANDING(MAXO),
        .STALL_EVERY    (SE)
    ) dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .wb_cyc  (wb_cyc),
        .wb_stb  (wb_stb),
        .wb_we   (wb_we),
        .wb_addr (wb_addr),
        .wb_sel  (wb_sel),
        .wb_mosi (wb_mosi),
        .wb_miso (wb_miso),
        .wb_ack  (wb_ack),
        .wb_err  (wb_err),
        .wb_stall(wb_stall)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;

    always @(posedge i_clk) cyc_n <= cyc_n + 1;

    // Model: every accepted request becomes an entry due at accept cycle + LAT.
    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        q_m[$];
    logic [31:0] mem_m [DEPTH];
    int          pat_m   = 0;
    logic        stall_m = 1'b0;
    logic [33:0] rsp_at [int];

    always @(negedge i_clk) begin
        logic        e_ack;
        logic        e_err;
        logic [31:0] e_data;
        logic        acc;
        logic        pat;
        exp_t        e;
        int          idx;
        e_ack  = 1'b0;
        e_err  = 1'b0;
        e_data = 32'h0;
        if (i_reset) begin
            q_m.delete();
            pat_m   = 0;
            stall_m = 1'b0;
        end else if (q_m.size() > 0 && q_m[0].due == cyc_n && wb_cyc) begin
            e_ack  = !q_m[0].err;
            e_err  = q_m[0].err;
            e_data = q_m[0].err ? 32'h0 : q_m[0].data;
        end
        checks++;
        if ({wb_ack, wb_err, wb_stall, wb_miso} !== {e_ack, e_err, stall_m, e_data}) begin
            errors++;
            $display("FAIL cycle_cmp cyc=%0d got ack=%b err=%b stall=%b miso=%h exp ack=%b err=%b stall=%b miso=%h",
                     cyc_n, wb_ack, wb_err, wb_stall, wb_miso, e_ack, e_err, stall_m, e_data);
        end
        if (wb_ack || wb_err) rsp_at[cyc_n] = {wb_ack, wb_err, wb_miso};

        if (!i_reset) begin
            if (q_m.size() > 0 && q_m[0].due == cyc_n) void'(q_m.pop_front());
            if (!wb_cyc) begin
                q_m.delete();
                stall_m = 1'b0;
            end else begin
                acc = wb_stb && !stall_m;
                pat = 1'b0;
                if (acc) begin
                    e.due  = cyc_n + LAT;
                    e.err  = (wb_addr < BASE) || (wb_addr >= BASE + DEPTH);
                    e.data = 32'h0;
                    if (!e.err) begin
                        idx = int'(wb_addr - BASE);
                        if (wb_we) begin
                            for (int i = 0; i < 4; i++)
                                if (wb_sel[i]) mem_m[idx][8*i +: 8] = wb_mosi[8*i +: 8];
                        end else begin
                            e.data = mem_m[idx];
                        end
                    end
                    q_m.push_back(e);
                    pat_m++;
                    if (pat_m == SE) begin
                        pat_m = 0;
                        pat   = 1'b1;
                    end
                end
                stall_m = ((q_m.size() == MAXO) && !(q_m.size() > 0 && q_m[0].due == cyc_n + 1)) || pat;
            end
        end
    end

    task automatic issue(input logic we, input logic [29:0] addr, input logic [3:0] sel,
                         input logic [31:0] data, output int acc);
        acc = -1;
        @(posedge i_clk);
        #1;
        wb_cyc  = 1'b1;
        wb_stb  = 1'b1;
        wb_we   = we;
        wb_addr = addr;
        wb_sel  = sel;
        wb_mosi = data;
        for (int n = 0; n < 40; n++) begin
            @(negedge i_clk);
            if (!wb_stall) begin
                acc = cyc_n;
                break;
            end
        end
        checks++;
        if (acc < 0) begin
            errors++;
            $display("FAIL accept_timeout addr=%h got no accept within 40 cycles", addr);
        end
    endtask

    task automatic idle(input int n);
        @(posedge i_clk);
        #1;
        wb_stb = 1'b0;
        wb_we  = 1'b0;
        repeat (n) @(negedge i_clk);
    endtask

    task automatic check_rsp(input string name, input int acc, input logic e_err, input logic [31:0] e_data);
        int key;
        key = acc + 3;
        checks++;
        if (!rsp_at.exists(key)) begin
            errors++;
            $display("FAIL %s got no response at cycle %0d required ack=%b err=%b", name, key, ~e_err, e_err);
        end else if (rsp_at[key] !== {~e_err, e_err, e_data}) begin
            errors++;
            $display("FAIL %s got ack/err/data=%h required %h", name, rsp_at[key], {~e_err, e_err, e_data});
        end
    endtask

    task automatic check_none(input string name, input int cycle);
        checks++;
        if (rsp_at.exists(cycle)) begin
            errors++;
            $display("FAIL %s got response %h at cycle %0d required none", name, rsp_at[cycle], cycle);
        end
    endtask

    task automatic check_int(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s got %0d required %0d", name, got, req);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0, a1, w0, w1, w2, r0, r1, e0, e1, rl, rh, c0, c1, c2, m0, m1;
        int acc6 [6];
        int off [6];
        logic [29:0] adr6 [6];
        logic [31:0] dat6 [6];
        off  = '{0, 1, 3, 4, 6, 8};
        adr6 = '{30'h110, 30'h120, 30'h100, 30'h1FF, 30'h110, 30'h120};
        dat6 = '{32'hDEADBEEF, 32'h11BB33DD, 32'hCAFE0100, 32'h0BADF00D, 32'hDEADBEEF, 32'h11BB33DD};

        repeat (3) @(negedge i_clk);
        checks++;
        if ({wb_ack, wb_err, wb_stall, wb_miso} !== 35'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h required 0", {wb_ack, wb_err, wb_stall, wb_miso});
        end
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        @(negedge i_clk);

        // Basic write then read-after-write.
        issue(1'b1, 30'h110, 4'hF, 32'hDEADBEEF, a0);
        issue(1'b0, 30'h110, 4'hF, 32'h0, a1);
        idle(6);
        check_rsp("t1_write_ack", a0, 1'b0, 32'h0);
        check_rsp("t1_read_data", a1, 1'b0, 32'hDEADBEEF);

        // Byte lanes and an empty-lane write.
        issue(1'b1, 30'h120, 4'hF, 32'h11223344, w0);
        issue(1'b1, 30'h120, 4'b0101, 32'hAABBCCDD, w1);
        issue(1'b0, 30'h120, 4'h0, 32'h0, r0);
        issue(1'b1, 30'h120, 4'h0, 32'hFFFFFFFF, w2);
        issue(1'b0, 30'h120, 4'hF, 32'h0, r1);
        idle(8);
        check_rsp("t2_lane_read", r0, 1'b0, 32'h11BB33DD);
        check_rsp("t2_sel0_ack", w2, 1'b0, 32'h0);
        check_rsp("t2_sel0_read", r1, 1'b0, 32'h11BB33DD);

        // Decode window edges and out-of-range errors.
        issue(1'b1, 30'h100, 4'hF, 32'hCAFE0100, w0);
        issue(1'b1, 30'h1FF, 4'hF, 32'h0BADF00D, w1);
        issue(1'b0, 30'h0FF, 4'hF, 32'h0, e0);
        issue(1'b1, 30'h200, 4'hF, 32'h55555555, e1);
        issue(1'b0, 30'h100, 4'hF, 32'h0, rl);
        issue(1'b0, 30'h1FF, 4'hF, 32'h0, rh);
        idle(8);
        check_rsp("t3_err_below", e0, 1'b1, 32'h0);
        check_rsp("t3_err_above", e1, 1'b1, 32'h0);
        check_rsp("t3_read_low", rl, 1'b0, 32'hCAFE0100);
        check_rsp("t3_read_high", rh, 1'b0, 32'h0BADF00D);

        // Six held reads after reset: occupancy and periodic stalls.
        @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        wb_cyc  = 1'b0;
        repeat (2) @(negedge i_clk);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        @(negedge i_clk);
        for (int i = 0; i < 6; i++) issue(1'b0, adr6[i], 4'hF, 32'h0, acc6[i]);
        idle(8);
        for (int i = 1; i < 6; i++) check_int($sformatf("t4_accept_offset%0d", i), acc6[i] - acc6[0], off[i]);
        for (int i = 0; i < 6; i++) check_rsp($sformatf("t4_read%0d", i), acc6[i], 1'b0, dat6[i]);

        // Abort with two reads in flight, then a fresh read.
        issue(1'b0, 30'h110, 4'hF, 32'h0, c0);
        issue(1'b0, 30'h120, 4'hF, 32'h0, c1);
        @(posedge i_clk);
        #1;
        wb_cyc = 1'b0;
        wb_stb = 1'b0;
        @(negedge i_clk);
        issue(1'b0, 30'h100, 4'hF, 32'h0, c2);
        idle(6);
        check_none("t6_abort_first", c0 + 3);
        check_none("t6_abort_second", c1 + 3);
        check_int("t6_restart_accept", c2 - c1, 2);
        check_rsp("t6_restart_read", c2, 1'b0, 32'hCAFE0100);

        // Reset in the middle of a burst.
        issue(1'b0, 30'h110, 4'hF, 32'h0, m0);
        issue(1'b0, 30'h120, 4'hF, 32'h0, m1);
        @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        wb_cyc  = 1'b0;
        wb_stb  = 1'b0;
        #1;
        checks++;
        if ({wb_ack, wb_err, wb_stall, wb_miso} !== 35'h0) begin
            errors++;
            $display("FAIL reset_midburst got %h required 0", {wb_ack, wb_err, wb_stall, wb_miso});
        end
        repeat (2) @(negedge i_clk);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        @(negedge i_clk);
        issue(1'b0, 30'h120, 4'hF, 32'h0, r0);
        issue(1'b0, 30'h1FF, 4'hF, 32'h0, r1);
        idle(6);
        check_none("t6_reset_lost0", m0 + 3);
        check_none("t6_reset_lost1", m1 + 3);
        check_rsp("t6_persist0", r0, 1'b0, 32'h11BB33DD);
        check_rsp("t6_persist1", r1, 1'b0, 32'h0BADF00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
